// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline occupancy/handshake controller
// with register-scoreboard issue blocking and a redirect flush.
module pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int REG_CNT = 32,
    parameter int ISSUE_STAGE = 2,
    parameter int CNT_WIDTH = 16,
    localparam int REG_ADDR_WIDTH = $clog2(REG_CNT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STAGES-1:0]         stage_ready,
    output logic [STAGES-1:0]         stage_en,
    output logic [STAGES-1:0]         stage_load,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rd,
    input  logic                      dec_writes,
    input  logic                      flush,
    output logic                      retire,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    logic [STAGES-1:0]         stage_en_q, stage_en_d;
    logic [CNT_WIDTH-1:0]      stall_cnt_q, stall_cnt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q [ISSUE_STAGE:STAGES-1];
    logic [REG_ADDR_WIDTH-1:0] rd_d [ISSUE_STAGE:STAGES-1];
    logic                      wr_q [ISSUE_STAGE:STAGES-1];
    logic                      wr_d [ISSUE_STAGE:STAGES-1];

    logic [STAGES-1:0] done;
    logic [STAGES-1:0] leave;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] blk;
    logic              hazard;
    logic              flush_hit;
    logic              stall_inc;
    logic              accept;

    // Handshake: resolve transfers from the last stage backward, plus hazard.
    always_comb begin
        done      = stage_en_q & stage_ready;
        flush_hit = flush & done[STAGES-1];
        leave     = '0;
        load      = '0;
        blk       = '0;
        hazard    = 1'b0;
        accept    = 1'b0;
        for (int i = ISSUE_STAGE; i < STAGES; i++) begin
            if (stage_en_q[i] && wr_q[i] && (rd_q[i] != '0) &&
                ((rd_q[i] == dec_rs1) || (rd_q[i] == dec_rs2))) begin
                hazard = 1'b1;
            end
        end
        blk[ISSUE_STAGE] = hazard;
        leave[STAGES-1]  = done[STAGES-1];
        for (int i = STAGES - 1; i >= 1; i--) begin
            accept      = done[i-1] & (~stage_en_q[i] | leave[i]) & ~blk[i];
            load[i]     = accept;
            leave[i-1]  = accept;
        end
        load[0]   = ~stage_en_q[0] | leave[0];
        stall_inc = done[ISSUE_STAGE-1]
                  & (~stage_en_q[ISSUE_STAGE] | leave[ISSUE_STAGE])
                  & blk[ISSUE_STAGE];
        if (rst || flush_hit) begin
            load = '0;
        end
    end

    // Next occupancy, scoreboard tags and saturating stall counter.
    always_comb begin
        stage_en_d  = load | (stage_en_q & ~leave);
        stall_cnt_d = stall_cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (flush_hit) begin
            stage_en_d = '0;
            for (int i = ISSUE_STAGE; i < STAGES; i++) begin
                rd_d[i] = '0;
                wr_d[i] = 1'b0;
            end
        end else begin
            for (int i = ISSUE_STAGE + 1; i < STAGES; i++) begin
                if (load[i]) begin
                    rd_d[i] = rd_q[i-1];
                    wr_d[i] = wr_q[i-1];
                end
            end
            if (load[ISSUE_STAGE]) begin
                rd_d[ISSUE_STAGE] = dec_rd;
                wr_d[ISSUE_STAGE] = dec_writes;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_en_q  <= '0;
            stall_cnt_q <= '0;
            for (int i = ISSUE_STAGE; i < STAGES; i++) begin
                rd_q[i] <= '0;
                wr_q[i] <= 1'b0;
            end
        end else begin
            stage_en_q  <= stage_en_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = ISSUE_STAGE; i < STAGES; i++) begin
                rd_q[i] <= rd_d[i];
                wr_q[i] <= wr_d[i];
            end
        end
    end

    assign stage_en   = stage_en_q;
    assign stage_load = load;
    assign retire     = ~rst & done[STAGES-1];
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector bench for pipe_ctrl (STAGES=4, ISSUE=2)
// plus a narrow-counter twin that shares all inputs for saturation.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] stage_ready;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_writes;
    logic       flush;

    logic [3:0]  stage_en, stage_load;
    logic        retire;
    logic [15:0] stall_cnt;

    logic [3:0] s_en, s_load;
    logic       s_retire;
    logic [1:0] s_stall;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .stage_ready(stage_ready),
        .stage_en(stage_en), .stage_load(stage_load),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_writes(dec_writes), .flush(flush),
        .retire(retire), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .stage_ready(stage_ready),
        .stage_en(s_en), .stage_load(s_load),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_writes(dec_writes), .flush(flush),
        .retire(s_retire), .stall_cnt(s_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [3:0]  rdy;
        logic [4:0]  rs1, rs2, rd;
        logic        wr, fl;
        logic [3:0]  en, ld;
        logic        ret;
        logic [15:0] st;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic [3:0] rdy,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] rd, input logic wr, input logic fl,
        input logic [3:0] en, input logic [3:0] ld,
        input logic ret, input logic [15:0] st);
        vec_t v;
        v.r = r; v.rdy = rdy; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.wr = wr; v.fl = fl; v.en = en; v.ld = ld; v.ret = ret; v.st = st;
        return v;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        logic [15:0] sat_exp;
        rst = v.r; stage_ready = v.rdy;
        dec_rs1 = v.rs1; dec_rs2 = v.rs2; dec_rd = v.rd;
        dec_writes = v.wr; flush = v.fl;
        sat_exp = (v.st > 16'd3) ? 16'd3 : v.st;
        @(negedge clk);
        chk(tag, "stage_en", {12'd0, stage_en}, {12'd0, v.en});
        chk(tag, "stage_load", {12'd0, stage_load}, {12'd0, v.ld});
        chk(tag, "retire", {15'd0, retire}, {15'd0, v.ret});
        chk(tag, "stall_cnt", stall_cnt, v.st);
        chk(tag, "sat_stall", {14'd0, s_stall}, sat_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(mk(1, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0), tag);
    endtask

    // Common two-cycle fill after reset: no hazards yet.
    task automatic fill2(input string tag);
        step(mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h1, 0, 0), {tag, "_c0"});
        step(mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h1, 4'h3, 0, 0), {tag, "_c1"});
    endtask

    vec_t tbl [20];

    initial begin
        rst = 1'b1; stage_ready = 4'hF; flush = 1'b0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_writes = 1'b0;

        // Fill, backpressure at stage 2, flush, mid-stream reset.
        tbl[0]  = mk(1, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        tbl[1]  = mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h1, 0, 0);
        tbl[2]  = mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h1, 4'h3, 0, 0);
        tbl[3]  = mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h3, 4'h7, 0, 0);
        tbl[4]  = mk(0, 4'hF, 0, 0, 0, 0, 1, 4'h7, 4'hF, 0, 0);
        tbl[5]  = mk(0, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'hF, 1, 0);
        tbl[6]  = mk(0, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'hF, 1, 0);
        tbl[7]  = mk(0, 4'hB, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 0);
        tbl[8]  = mk(0, 4'hB, 0, 0, 0, 0, 0, 4'h7, 4'h0, 0, 0);
        tbl[9]  = mk(0, 4'hB, 0, 0, 0, 0, 0, 4'h7, 4'h0, 0, 0);
        tbl[10] = mk(0, 4'hB, 0, 0, 0, 0, 0, 4'h7, 4'h0, 0, 0);
        tbl[11] = mk(0, 4'hB, 0, 0, 0, 0, 0, 4'h7, 4'h0, 0, 0);
        tbl[12] = mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h7, 4'hF, 0, 0);
        tbl[13] = mk(0, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'hF, 1, 0);
        tbl[14] = mk(0, 4'hF, 0, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0);
        tbl[15] = mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h1, 0, 0);
        tbl[16] = mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h1, 4'h3, 0, 0);
        tbl[17] = mk(1, 4'hF, 0, 0, 0, 0, 0, 4'h3, 4'h0, 0, 0);
        tbl[18] = mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h1, 0, 0);
        tbl[19] = mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h1, 4'h3, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            step(tbl[i], $sformatf("tbl%0d", i));
        end

        // Writer of x5 followed by a reader of x5.
        do_reset("haz_rst");
        fill2("haz");
        step(mk(0, 4'hF, 0, 0, 5, 1, 0, 4'h3, 4'h7, 0, 0), "haz_c2");
        step(mk(0, 4'hF, 5, 0, 0, 0, 0, 4'h7, 4'h8, 0, 0), "haz_c3");
        step(mk(0, 4'hF, 5, 0, 0, 0, 0, 4'hB, 4'h0, 1, 1), "haz_c4");
        step(mk(0, 4'hF, 5, 0, 0, 0, 0, 4'h3, 4'h7, 0, 2), "haz_c5");
        step(mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h7, 4'hF, 0, 2), "haz_c6");

        // x0 writer and a non-writing rd never stall.
        do_reset("x0_rst");
        fill2("x0");
        step(mk(0, 4'hF, 0, 0, 0, 1, 0, 4'h3, 4'h7, 0, 0), "x0_c2");
        step(mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h7, 4'hF, 0, 0), "x0_c3");
        step(mk(0, 4'hF, 0, 0, 5, 0, 0, 4'hF, 4'hF, 1, 0), "x0_c4");
        step(mk(0, 4'hF, 5, 5, 0, 0, 0, 4'hF, 4'hF, 1, 0), "x0_c5");
        step(mk(0, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'hF, 1, 0), "x0_c6");

        // Two writers of x7 then a reader on rs2.
        do_reset("w2_rst");
        fill2("w2");
        step(mk(0, 4'hF, 0, 0, 7, 1, 0, 4'h3, 4'h7, 0, 0), "w2_c2");
        step(mk(0, 4'hF, 0, 0, 7, 1, 0, 4'h7, 4'hF, 0, 0), "w2_c3");
        step(mk(0, 4'hF, 0, 7, 0, 0, 0, 4'hF, 4'h8, 1, 0), "w2_c4");
        step(mk(0, 4'hF, 0, 7, 0, 0, 0, 4'hB, 4'h0, 1, 1), "w2_c5");
        step(mk(0, 4'hF, 0, 7, 0, 0, 0, 4'h3, 4'h7, 0, 2), "w2_c6");
        step(mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h7, 4'hF, 0, 2), "w2_c7");

        // Long hazard with the writer stuck in stage 3: counter saturation.
        do_reset("sat_rst");
        fill2("sat");
        step(mk(0, 4'hF, 0, 0, 9, 1, 0, 4'h3, 4'h7, 0, 0), "sat_c2");
        step(mk(0, 4'hF, 9, 0, 0, 0, 0, 4'h7, 4'h8, 0, 0), "sat_c3");
        for (int k = 0; k < 5; k++) begin
            step(mk(0, 4'h7, 9, 0, 0, 0, 0, 4'hB, 4'h0, 0, 16'(k + 1)),
                 $sformatf("sat_hold%0d", k));
        end
        step(mk(0, 4'hF, 9, 0, 0, 0, 0, 4'hB, 4'h0, 1, 6), "sat_c9");
        step(mk(0, 4'hF, 9, 0, 0, 0, 0, 4'h3, 4'h7, 0, 7), "sat_c10");
        step(mk(0, 4'hF, 0, 0, 0, 0, 0, 4'h7, 4'hF, 0, 7), "sat_c11");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
